// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   div_state_t : controller state encoding (IDLE / RUN / DONE)
//   DIV_ZERO_Q  : quotient returned for a divide-by-zero request; the
//                 controller keeps the low WIDTH bits, giving all ones.
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_divider_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_divider_ctrl_if
// Operand and result handshake bundle of the sequential divider.
//   in_valid / in_ready : operand handshake, a = dividend, b = divisor
//   out_valid / out_ready : result handshake, q = quotient, r = remainder,
//                           div_zero = result came from a b==0 request
// Modports:
//   master : producer of operands and consumer of results
//   slave  : the divider controller
// ---------------------------------------------------------------------------
interface seq_divider_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q,
    input  r,
    input  div_zero
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q,
    output r,
    output div_zero
  );

endinterface

// File: rtl/div_row.sv
// ---------------------------------------------------------------------------
// div_row
// One combinational restoring-division step.
//   i_sh    : shifted partial remainder {rem, next dividend bit}, WIDTH+1 bits
//   i_b     : divisor
//   o_rem   : next partial remainder (WIDTH bits)
//   o_q_bit : quotient bit produced by this step
// The partial remainder entering a step is always below the divisor, so the
// restored value (i_sh) is below the divisor as well and its top bit is zero;
// only the low WIDTH bits need to be carried forward.
// ---------------------------------------------------------------------------
module div_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_sh,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_t;

  assign w_t     = i_sh - {1'b0, i_b};
  // A clear sign bit means the trial subtraction fit.
  assign o_q_bit = ~w_t[WIDTH];

  // Keep the difference when it fit, otherwise restore the shifted value.
  always_comb begin
    o_rem = i_sh[WIDTH-1:0];
    if (o_q_bit) begin
      o_rem = w_t[WIDTH-1:0];
    end else begin
      o_rem = i_sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider_ctrl.sv
// ---------------------------------------------------------------------------
// seq_divider_ctrl
// Sequential unsigned divider: accepts a/b, runs one restoring row per clock
// for WIDTH clocks, then presents q/r until the consumer takes them.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; discards any operation in flight
//   bus : seq_divider_ctrl_if.slave (operand and result handshakes)
// A zero divisor skips the rows entirely and answers the next cycle with
// q = all ones, r = a, div_zero = 1.
// ---------------------------------------------------------------------------
module seq_divider_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_ctrl_if.slave  bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_div_zero;

  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_next;

  // Bring down the next dividend bit (MSB of the shifting quotient register).
  assign w_sh       = {r_rem, r_quo[WIDTH-1]};
  // Dividend bits shift out the top while quotient bits shift in the bottom.
  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};

  div_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .i_sh    (w_sh),
    .i_b     (r_b),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  // Controller FSM: operand capture, row sequencing and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_b         <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= {WIDTH{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_b        <= bus.b;
            r_quo      <= bus.a;
            r_rem      <= {WIDTH{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            if (bus.b == {WIDTH{1'b0}}) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_q         <= DIV_ZERO_Q[WIDTH-1:0];
              r_r         <= bus.a;
              r_div_zero  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          if (r_cnt == CNT_LAST) begin
            // Last row: publish the result straight from the row outputs.
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_q         <= w_quo_next;
            r_r         <= w_rem_next;
            r_div_zero  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.div_zero  = r_div_zero;

endmodule
